// File: rtl/ram_write_sequencer_if.sv
// ---------------------------------------------------------------------------
// ram_write_sequencer_if
//   RAM-side bus produced by ram_write_sequencer and consumed by the 4x1-bit
//   DFF RAM (and by board LEDs / verification monitors).
//
//   addr    [1:0]  RAM cell address
//   d              RAM data bit
//   wr_clk         single registered write-clock pulse
//   busy           high while a write sequence is in progress
//
//   master : the sequencer (drives everything)
//   slave  : the RAM / observers (read everything)
// ---------------------------------------------------------------------------
interface ram_write_sequencer_if;

    logic [1:0] addr;
    logic       d;
    logic       wr_clk;
    logic       busy;

    modport master (
        output addr,
        output d,
        output wr_clk,
        output busy
    );

    modport slave (
        input  addr,
        input  d,
        input  wr_clk,
        input  busy
    );

endinterface : ram_write_sequencer_if

// File: rtl/ram_write_sequencer.sv
// ---------------------------------------------------------------------------
// ram_write_sequencer
//   Turns raw push-buttons and a data switch into a clean RAM address, a data
//   bit and a single write-clock pulse. Address and data are frozen for one
//   clock on either side of the pulse so the RAM's address-decoded clock
//   steering can never glitch into the wrong cell. A shadow copy of the four
//   written bits and a write counter are kept for LEDs and verification.
//
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   i_btn_write    raw write button (active-high, bouncy, asynchronous)
//   i_btn_next     raw address-advance button (active-high, bouncy)
//   i_sw_data      raw data switch
//   ram            RAM bus (addr, d, wr_clk, busy), master side
//   o_mem_shadow   bit i = last value written to address i
//   o_wr_count     completed writes, mod 16
//   o_d_led        debounced sw_data level
// ---------------------------------------------------------------------------
module ram_write_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned STROBE_CYCLES   = 4,
    parameter bit          AUTO_INC        = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_btn_write,
    input  logic                         i_btn_next,
    input  logic                         i_sw_data,
    ram_write_sequencer_if.master        ram,
    output logic [3:0]                   o_mem_shadow,
    output logic [3:0]                   o_wr_count,
    output logic                         o_d_led
);

    // -----------------------------------------------------------------------
    // Widths and constants
    // -----------------------------------------------------------------------
    localparam int unsigned N_IN  = 3;
    localparam int unsigned CH_WR = 0;
    localparam int unsigned CH_NX = 1;
    localparam int unsigned CH_SW = 2;

    localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned STB_W = (STROBE_CYCLES > 1)   ? $clog2(STROBE_CYCLES)   : 1;

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(STROBE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // Signals
    // -----------------------------------------------------------------------
    logic [N_IN-1:0] w_raw;
    logic [N_IN-1:0] r_sync1;
    logic [N_IN-1:0] r_sync2;
    logic [N_IN-1:0] r_db;
    logic [N_IN-1:0] r_db_q;
    logic [DB_W-1:0] r_db_cnt [N_IN];

    logic            w_wr_req;
    logic            w_nx_req;

    state_t          r_state;
    logic [1:0]      r_addr;
    logic            r_d;
    logic            r_wr_clk;
    logic            r_busy;
    logic [3:0]      r_mem;
    logic [3:0]      r_wr_count;
    logic [STB_W-1:0] r_stb_cnt;

    assign w_raw = {i_sw_data, i_btn_next, i_btn_write};

    // -----------------------------------------------------------------------
    // 2-FF synchronizers followed by per-input debouncers. The counter only
    // runs while the synced value disagrees with the accepted level, so any
    // bounce shorter than DEBOUNCE_CYCLES samples restarts it from zero.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db    <= '0;
            for (int i = 0; i < N_IN; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < N_IN; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_db[i]     <= ~r_db[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // One-clock requests on debounced press; releases produce nothing.
    assign w_wr_req = r_db[CH_WR] & ~r_db_q[CH_WR];
    assign w_nx_req = r_db[CH_NX] & ~r_db_q[CH_NX];

    // -----------------------------------------------------------------------
    // Write sequencer: IDLE -> SETUP -> PULSE (STROBE_CYCLES) -> HOLD -> IDLE.
    // All RAM-facing outputs are registers so wr_clk is glitch-free.
    // Requests seen outside IDLE are simply dropped.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_d        <= 1'b0;
            r_wr_clk   <= 1'b0;
            r_busy     <= 1'b0;
            r_mem      <= '0;
            r_wr_count <= '0;
            r_stb_cnt  <= '0;
            r_db_q     <= '0;
        end else begin
            r_db_q <= r_db;
            unique case (r_state)
                ST_IDLE: begin
                    // Write has priority; a simultaneous next request is lost.
                    if (w_wr_req) begin
                        r_d     <= r_db[CH_SW];
                        r_busy  <= 1'b1;
                        r_state <= ST_SETUP;
                    end else if (w_nx_req) begin
                        r_addr <= r_addr + 2'd1;
                    end
                end
                ST_SETUP: begin
                    r_wr_clk  <= 1'b1;
                    r_stb_cnt <= '0;
                    r_state   <= ST_PULSE;
                end
                ST_PULSE: begin
                    if (r_stb_cnt == STB_LAST) begin
                        r_wr_clk <= 1'b0;
                        r_state  <= ST_HOLD;
                    end else begin
                        r_stb_cnt <= r_stb_cnt + STB_W'(1);
                    end
                end
                ST_HOLD: begin
                    // Address still old here; the write is committed on exit.
                    r_mem[r_addr] <= r_d;
                    r_wr_count    <= r_wr_count + 4'd1;
                    if (AUTO_INC) begin
                        r_addr <= r_addr + 2'd1;
                    end
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_wr_clk <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output mapping
    // -----------------------------------------------------------------------
    assign ram.addr     = r_addr;
    assign ram.d        = r_d;
    assign ram.wr_clk   = r_wr_clk;
    assign ram.busy     = r_busy;
    assign o_mem_shadow = r_mem;
    assign o_wr_count   = r_wr_count;
    assign o_d_led      = r_db[CH_SW];

endmodule : ram_write_sequencer

// File: doc/ram_write_sequencer.md
Name: ram_write_sequencer

Overview:
- Front-end stage that drives the 4x1-bit DFF RAM: converts raw push-buttons and a data switch into a clean address, a data bit and a single write-clock pulse.
- Address and data are held stable around every pulse, so the RAM's address-decoded clock steering never glitches into a wrong cell.
- Also keeps a shadow copy of the four written bits and a write counter for board LEDs and for verification.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive stable synchronized samples needed to accept a new button/switch level (5 ms at 50 MHz)
STROBE_CYCLES, 4, width of wr_clk high pulse in clocks (>=1)
AUTO_INC, 1, 1 = advance address after each write, 0 = address changes only via btn_next

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
btn_write  input  1  raw write button, active-high, asynchronous/bouncy
btn_next  input  1  raw address-advance button, active-high
sw_data  input  1  raw data switch
addr  output  2  RAM address, to RAM addr
d  output  1  RAM data bit, to RAM d
wr_clk  output  1  write clock pulse, to RAM clk
busy  output  1  high while a write sequence is in progress
mem_shadow  output  4  bit i = last value written to address i
wr_count  output  4  number of completed writes, mod 16
d_led  output  1  debounced sw_data level

Behaviour:
- Reset (async assert, sync-release use): addr=0, d=0, wr_clk=0, busy=0, mem_shadow=0, wr_count=0, d_led=0, FSM=IDLE, all synchronizer and debounced levels 0, debounce counters 0. Reset mid-pulse drops wr_clk immediately; the partial write is not counted and not shadowed.
- Input conditioning, per raw input: 2-FF synchronizer -> debouncer.
  - Debouncer counter clears whenever synced value equals debounced level; otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 and synced value still differs, the debounced level toggles on that edge and the counter clears.
  - A bounce shorter than DEBOUNCE_CYCLES never changes the level.
- Edge detect: one-clock request on debounced 0->1 of btn_write (wr_req) and btn_next (nx_req). Releases generate nothing.
- FSM (one-hot or encoded, implementer's choice):
  - IDLE:
    - wr_req -> SETUP; latch d = debounced sw_data; busy=1 from next clock.
    - Else nx_req -> addr = addr+1 (wraps 3->0); stay IDLE.
    - wr_req and nx_req in the same cycle: write wins, nx_req dropped.
  - SETUP: 1 clock, wr_clk=0, addr/d stable -> PULSE.
  - PULSE: wr_clk=1 for exactly STROBE_CYCLES clocks -> HOLD.
  - HOLD: 1 clock, wr_clk=0, addr/d still stable.
    - Updates: mem_shadow[addr]=d, wr_count+1 (wraps 15->0).
    - If AUTO_INC=1, addr+1 (wraps) takes effect on exit.
    - -> IDLE, busy=0.
- Requests (wr_req, nx_req) arriving while busy are discarded, not queued.
- sw_data changes while busy do not affect d until the next SETUP. d_led follows debounced sw_data at all times.
- wr_clk is a registered output: glitch-free, no combinational path from inputs.
- Sequence length: busy high for STROBE_CYCLES+2 clocks. wr_clk rises exactly 1 clock after busy rises.

Test Plan:
(Bench uses DEBOUNCE_CYCLES=4, STROBE_CYCLES=2, AUTO_INC=1.)
1. Reset, then sw_data=1, press btn_write clean for 20 clocks:
   - exactly one wr_clk pulse, 2 clocks wide, with addr=0 and d=1 stable from 1 clock before to 1 clock after.
   - Then mem_shadow=0001, wr_count=1, addr=1, busy high 4 clocks.
2. btn_write bounces 1/0 every 2 clocks for 12 clocks, then steady 1:
   - exactly one write.
   - No wr_clk during the bounce period.
3. Four writes with sw_data = 1,0,1,1:
   - mem_shadow=1101, addr wraps back to 0, wr_count=4.
4. Set AUTO_INC=0. Press btn_next 3 times, then write sw_data=1:
   - addr=3, mem_shadow=1000.
   - btn_next pressed while busy is ignored (addr stays 3).
5. Align debounced btn_write and btn_next rising edges on the same clock:
   - write occurs at the current addr.
   - Address advances only by AUTO_INC, not by nx_req.
6. Assert rst_n=0 during PULSE:
   - wr_clk=0 asynchronously; addr, mem_shadow and wr_count all return to 0.
   - After release, no spurious write while buttons are held released.
